// File: rtl/core_inst_seq.sv
// Autonomous 64-bit inst sequencer for one 3x3 conv layer: W_L0 -> W_LOAD -> GAP -> EXEC -> DRAIN per kij, then FIN.
// inst is registered one cycle behind phase; no backpressure. CORE_INST_SEQ_READBACK_EN adds a psum readback pass before FIN.
module core_inst_seq #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int in_w    = 6,
    parameter int k_w     = 3,
    parameter int out_w   = 4,
    parameter int gap_cyc = 10,
    parameter int w_base  = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [63:0] inst,
    output logic        busy,
    output logic        done,
    output logic [3:0]  kij_idx,
    output logic [2:0]  phase
);

    localparam int LEN_NIJ  = in_w * in_w;
    localparam int LEN_KIJ  = k_w * k_w;
    localparam int LEN_ONIJ = out_w * out_w;
    localparam int CW       = 8;
    localparam int XW       = $clog2(in_w);
    localparam int NW       = $clog2(LEN_NIJ + 1);

    localparam logic [CW-1:0] WL0_LAST   = CW'(col + 1);
    localparam logic [CW-1:0] LOAD_LAST  = CW'(col + row);
    localparam logic [CW-1:0] GAP_LAST   = CW'(gap_cyc - 1);
    localparam logic [CW-1:0] EXEC_LAST  = CW'(LEN_NIJ + col + row);
    localparam logic [CW-1:0] NIJ_END    = CW'(LEN_NIJ);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(1);
    localparam logic [CW-1:0] RB_LAST    = CW'(LEN_ONIJ - 1);
    localparam logic [3:0]    KIJ_LAST   = 4'(LEN_KIJ - 1);
    localparam logic [XW-1:0] X_LAST     = XW'(in_w - 1);
    localparam logic [XW-1:0] KX_LAST    = XW'(k_w - 1);
    localparam logic [XW-1:0] OUT_W_X    = XW'(out_w);
    localparam logic [NW-1:0] NIJ_MAX    = NW'(LEN_NIJ);
    localparam logic [63:0]   INST_RST   = 64'h0000_0001_000C_0000;

    typedef struct packed {
        logic        debug;
        logic [16:0] rsv_hi;
        logic        relu;
        logic [8:0]  rsv_mid;
        logic        ren_pmem;
        logic        sfu_pass;
        logic        acc;
        logic        cen_pmem;
        logic        wen_pmem;
        logic [10:0] a_pmem;
        logic        cen_xmem;
        logic        wen_xmem;
        logic [10:0] a_xmem;
        logic        ofifo_rd;
        logic        ififo_wr;
        logic        ififo_rd;
        logic        l0_rd;
        logic        l0_wr;
        logic        execute;
        logic        load;
    } inst_t;

`ifdef CORE_INST_SEQ_READBACK_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_W_L0 = 3'd1, S_W_LOAD = 3'd2, S_GAP = 3'd3,
        S_EXEC = 3'd4, S_DRAIN = 3'd5, S_FIN = 3'd6, S_READBACK = 3'd7
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_W_L0 = 3'd1, S_W_LOAD = 3'd2, S_GAP = 3'd3,
        S_EXEC = 3'd4, S_DRAIN = 3'd5, S_FIN = 3'd6
    } state_t;
`endif

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    kij, kij_nxt;
    logic [XW-1:0] kx, kx_nxt, ky, ky_nxt;
    logic [XW-1:0] nx, nx_nxt, ny, ny_nxt;
    logic [NW-1:0] nij, nij_nxt;
    logic          busy_nxt, done_nxt;
    inst_t         inst_q, inst_nxt;
    logic          map_ok;
    logic [XW-1:0] ox, oy;
    logic [10:0]   pmem_addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            kij    <= '0;
            kx     <= '0;
            ky     <= '0;
            nx     <= '0;
            ny     <= '0;
            nij    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            inst_q <= inst_t'(INST_RST);
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            kij    <= kij_nxt;
            kx     <= kx_nxt;
            ky     <= ky_nxt;
            nx     <= nx_nxt;
            ny     <= ny_nxt;
            nij    <= nij_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
            inst_q <= inst_nxt;
        end
    end

    // Output position of the OFIFO row about to be read; kx/ky are kij%k_w and kij/k_w.
    always_comb begin
        ox        = nx - kx;
        oy        = ny - ky;
        map_ok    = (nx >= kx) && (ny >= ky) && (ox < OUT_W_X) && (oy < OUT_W_X);
        pmem_addr = 11'(ox) + 11'(oy) * 11'(out_w);
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        kij_nxt   = kij;
        kx_nxt    = kx;
        ky_nxt    = ky;
        nx_nxt    = nx;
        ny_nxt    = ny;
        nij_nxt   = nij;
        busy_nxt  = 1'b1;
        done_nxt  = 1'b0;
        inst_nxt  = inst_t'(INST_RST);

        unique case (state)
            S_IDLE: begin
                cnt_nxt  = '0;
                busy_nxt = start;
                if (start) begin
                    state_nxt = S_W_L0;
                    kij_nxt   = '0;
                    kx_nxt    = '0;
                    ky_nxt    = '0;
                end
            end
            S_W_L0: begin
                inst_nxt.a_xmem   = 11'(w_base) + 11'(kij) * 11'(col) + 11'(cnt);
                inst_nxt.cen_xmem = 1'b0;
                inst_nxt.l0_wr    = (cnt != '0);
                // Row counters restart for every kij (nij count = rows consumed so far).
                nx_nxt  = '0;
                ny_nxt  = '0;
                nij_nxt = '0;
                if (cnt == WL0_LAST) begin
                    state_nxt = S_W_LOAD;
                    cnt_nxt   = '0;
                end
            end
            S_W_LOAD: begin
                inst_nxt.l0_rd = 1'b1;
                inst_nxt.load  = (cnt != '0);
                if (cnt == LOAD_LAST) begin
                    state_nxt = S_GAP;
                    cnt_nxt   = '0;
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = S_EXEC;
                    cnt_nxt   = '0;
                end
            end
            S_EXEC: begin
                // xmem is only addressed while CEN is low; otherwise A_xmem parks at 0.
                if (cnt <= NIJ_END) begin
                    inst_nxt.a_xmem   = 11'(cnt);
                    inst_nxt.cen_xmem = 1'b0;
                    inst_nxt.l0_wr    = 1'b1;
                    inst_nxt.l0_rd    = 1'b1;
                    inst_nxt.execute  = (cnt != '0);
                end
                if (cnt == EXEC_LAST) begin
                    state_nxt = S_DRAIN;
                    cnt_nxt   = '0;
                end
            end
            S_DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    cnt_nxt = '0;
                    if (kij == KIJ_LAST) begin
`ifdef CORE_INST_SEQ_READBACK_EN
                        state_nxt = S_READBACK;
`else
                        state_nxt = S_FIN;
`endif
                    end else begin
                        state_nxt = S_W_L0;
                        kij_nxt   = kij + 1'b1;
                        if (kx == KX_LAST) begin
                            kx_nxt = '0;
                            ky_nxt = ky + 1'b1;
                        end else begin
                            kx_nxt = kx + 1'b1;
                        end
                    end
                end
            end
`ifdef CORE_INST_SEQ_READBACK_EN
            S_READBACK: begin
                inst_nxt.cen_pmem = 1'b0;
                inst_nxt.wen_pmem = 1'b0;
                inst_nxt.a_pmem   = 11'(cnt);
                inst_nxt.debug    = 1'b1;
                if (cnt == RB_LAST) begin
                    state_nxt = S_FIN;
                    cnt_nxt   = '0;
                end
            end
`endif
            S_FIN: begin
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase

        // Every presented row is popped; rows past len_nij or off the output window are dropped.
        if ((state == S_EXEC || state == S_DRAIN) && ofifo_valid) begin
            inst_nxt.ofifo_rd = 1'b1;
            if (nij < NIJ_MAX) begin
                nij_nxt = nij + 1'b1;
                if (nx == X_LAST) begin
                    nx_nxt = '0;
                    ny_nxt = ny + 1'b1;
                end else begin
                    nx_nxt = nx + 1'b1;
                end
                if (map_ok) begin
                    inst_nxt.cen_pmem = 1'b0;
                    inst_nxt.wen_pmem = 1'b1;
                    inst_nxt.a_pmem   = pmem_addr;
                    inst_nxt.acc      = (kij != '0);
                    inst_nxt.sfu_pass = (kij == '0);
                    inst_nxt.relu     = (kij == KIJ_LAST);
                end
            end
        end
    end

    assign inst    = inst_q;
    assign kij_idx = kij;
    assign phase   = state;

endmodule

// File: doc/core_inst_seq.md
Name: core_inst_seq

Overview:
- Hardware instruction sequencer that autonomously produces the 64-bit `inst` word consumed by `core`.
- It replaces bench-driven stepping of one 3x3 convolution layer: for each kij it loads weights into L0 and the PE array, streams activations, then accumulates OFIFO rows into psum SRAM with output-index remapping.
- It sits beside `core`, observes `ofifo_valid`, and assumes activations are at xmem address 0 and kij weights at `w_base + kij*col`.

Parameters:
- row, 8, PE array rows (activation lanes)
- col, 8, PE array columns (output channels, weight rows per kij)
- in_w, 6, input feature-map width; len_nij = in_w*in_w
- k_w, 3, kernel width; len_kij = k_w*k_w
- out_w, 4, output width (in_w-k_w+1); len_onij = out_w*out_w
- gap_cyc, 10, idle cycles between weight load and execute
- w_base, 1024, xmem base address of kij-0 weights

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins a layer when in IDLE
- ofifo_valid  input  1  `core` OFIFO holds a complete row
- inst  output  64  instruction word to `core`
- busy  output  1  high from the cycle after `start` until DONE
- done  output  1  one-cycle pulse when the layer finishes
- kij_idx  output  4  current kernel index 0..len_kij-1
- phase  output  3  current FSM state encoding (debug)

Behaviour:
- inst field map:
  - bit0 load, bit1 execute, bit2 l0_wr, bit3 l0_rd, bit4 ififo_rd, bit5 ififo_wr, bit6 ofifo_rd
  - [17:7] A_xmem, bit18 WEN_xmem, bit19 CEN_xmem
  - [30:20] A_pmem, bit31 WEN_pmem (1 = psum write), bit32 CEN_pmem, bit33 acc
  - bit34 sfu_passthrough, bit35 REN_pmem, bit45 relu, bit63 debug
  - Unlisted bits are always 0; ififo bits are always 0.
- All inst bits are registered outputs.
- Reset value (async, while reset=0): inst = {CEN_xmem=1, WEN_xmem=1, CEN_pmem=1, all else 0}; busy=0, done=0, kij_idx=0, phase=IDLE.
- States:
  - IDLE: wait for start=1, then go to W_L0 with kij=0.
  - W_L0: A_xmem = w_base + kij*col, CEN_xmem=0, WEN_xmem=1. l0_wr=1 from the 2nd cycle. A_xmem increments each cycle after the first. Lasts col+2 cycles, then CEN_xmem=1, l0_wr=0.
  - W_LOAD: l0_rd=1 for col+row+1 cycles; load=1 on all but the first of those cycles.
  - GAP: all strobes 0 for gap_cyc cycles.
  - EXEC: len_nij+col+row+1 cycles.
    - Cycle 0: A_xmem=0, CEN_xmem=0, l0_wr=1, l0_rd=1.
    - Cycles 1..len_nij: A_xmem+1 each cycle, execute=1. After that, execute=l0_rd=0.
    - Psum handling (below) runs in parallel.
  - DRAIN: 2 cycles; all strobes deasserted. Then: if kij==len_kij-1 go to FIN, else kij+1 and go to W_L0.
  - FIN: done=1 for one cycle, busy=0, then IDLE.
- Psum handling, in EXEC and DRAIN, on each cycle where ofifo_valid=1:
  - Assert ofifo_rd=1 and CEN_pmem=0; advance nij (starts at -1 per kij).
  - Counters nx, ny wrap at in_w; no divider. kx = kij%k_w, ky = kij/k_w, held in counters.
  - ox = nx-kx, oy = ny-ky. Valid iff 0<=ox<out_w and 0<=oy<out_w; then A_pmem = ox + oy*out_w and WEN_pmem=1.
  - Invalid mapping: CEN_pmem=1, WEN_pmem=0, ofifo_rd still 1 (row discarded).
  - kij==0: sfu_passthrough=1, acc=0. Otherwise sfu_passthrough=0, acc=1.
  - relu=1 only when kij==len_kij-1.
- start while busy: ignored.
- ofifo_valid outside EXEC/DRAIN: ignored, ofifo_rd=0.
- nij overflow: if more than len_nij valid rows arrive, extra rows are read out (ofifo_rd=1) with CEN_pmem=1.
- Reset mid-operation returns to IDLE immediately with reset values; no partial done.

Optional Feature:
- Macro: CORE_INST_SEQ_READBACK_EN.
- Defined: FIN is preceded by a READBACK state of len_onij cycles: CEN_pmem=0, WEN_pmem=0, acc=0, sfu_passthrough=0, debug=1, A_pmem=0..len_onij-1. done pulses after the last address.
- Undefined: no READBACK state; inst[63] is tied to 0.

Test Plan:
- Reset=0 asserted mid-EXEC -> inst = 64'h0000_0001_000C_0000 in the same cycle, busy=0, phase=IDLE.
- start with ofifo_valid=0 throughout -> exactly 9 W_L0/W_LOAD/GAP/EXEC/DRAIN rounds; first W_L0 A_xmem=1024, kij=8 A_xmem=1088; done after the final round; total cycles match the formula.
- kij=4, ofifo_valid held high in EXEC -> nij=0..6 give invalid mapping (CEN_pmem=1); nij=7 gives A_pmem=0 with WEN_pmem=1, acc=1; nij=28 gives A_pmem=15.
- kij=0 -> sfu_passthrough=1, acc=0 on writes; kij=8 -> relu=1 on every accumulation write.
- start pulsed while busy, and ofifo_valid pulsed in GAP -> no restart, ofifo_rd stays 0.
- CORE_INST_SEQ_READBACK_EN defined -> 16 readback cycles, A_pmem 0..15, inst[63]=1, then done.
